// File: rtl/rc4_pkg.sv
// rc4_pkg -- shared types and constants for the RC4 key-search engine.
//   rc4_state_e  : top-level FSM states
//   swap_step_e  : steps of the shared read/read/write/write swap sequence
//   prga_step_e  : per-byte PRGA phases that follow the swap
//   swap_mode_e  : selects the j-update term (key byte in KSA, none in PRGA)
//   FILT_*       : printable-text filter range (used with RC4_ASCII_FILTER_EN)
//   *_CYCLES     : per-phase cycle counts
package rc4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_INIT, ST_KSA, ST_PRGA, ST_NEXT, ST_HIT, ST_DONE
    } rc4_state_e;

    typedef enum logic [2:0] {
        SW_RI, SW_WI, SW_RJ, SW_WJ, SW_SI, SW_SJ
    } swap_step_e;

    typedef enum logic [1:0] {
        PR_SWAP, PR_RF, PR_WF, PR_OUT
    } prga_step_e;

    typedef enum logic {
        SWAP_KSA, SWAP_PRGA
    } swap_mode_e;

    localparam logic [7:0] FILT_LO = 8'h61;
    localparam logic [7:0] FILT_HI = 8'h7A;
    localparam logic [7:0] FILT_SP = 8'h20;

    localparam int INIT_CYCLES      = 256;
    localparam int SWAP_CYCLES      = 6;
    localparam int KSA_CYCLES       = INIT_CYCLES * SWAP_CYCLES;
    localparam int PRGA_BYTE_CYCLES = SWAP_CYCLES + 3;

    function automatic logic is_text(input logic [7:0] b);
        return ((b >= FILT_LO) && (b <= FILT_HI)) || (b == FILT_SP);
    endfunction

endpackage

// File: rtl/rc4_swap_seq.sv
// rc4_swap_seq -- six-step S-box swap sequencer shared by KSA and PRGA.
// While run=1 it cycles RI, WI, RJ, WJ, SI, SJ: reads S[i], updates j,
// reads S[j], writes S[i]=S[j], writes S[j]=old S[i].
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   run                 advance one step per cycle
//   clear_j             force j to zero
//   mode                SWAP_KSA adds key_byte to j, SWAP_PRGA does not
//   i_idx, key_byte     current i and key byte
//   s_rdata             S RAM read data
//   s_addr/s_wdata/s_wren  S RAM request for the current step
//   f_idx               S[i]+S[j] of the last swap (keystream index)
//   last                high in the final (SJ) step
module rc4_swap_seq
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       clear_j,
    input  swap_mode_e mode,
    input  logic [7:0] i_idx,
    input  logic [7:0] key_byte,
    input  logic [7:0] s_rdata,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_wren,
    output logic [7:0] f_idx,
    output logic       last
);
    swap_step_e step_q, step_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] j_add;

    always_comb begin
        step_d  = step_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        s_addr  = '0;
        s_wdata = '0;
        s_wren  = 1'b0;
        j_add   = (mode == SWAP_KSA) ? key_byte : 8'h00;
        last    = run && (step_q == SW_SJ);
        if (run) begin
            step_d = last ? SW_RI : swap_step_e'(step_q + 3'd1);
            unique case (step_q)
                SW_RI: s_addr = i_idx;
                SW_WI: begin
                    s_addr = i_idx;
                    si_d   = s_rdata;
                end
                SW_RJ: begin
                    j_d    = j_q + si_q + j_add;
                    s_addr = j_d;
                end
                SW_WJ: begin
                    s_addr = j_q;
                    sj_d   = s_rdata;
                end
                SW_SI: begin
                    s_addr  = i_idx;
                    s_wdata = sj_q;
                    s_wren  = 1'b1;
                end
                SW_SJ: begin
                    s_addr  = j_q;
                    s_wdata = si_q;
                    s_wren  = 1'b1;
                end
                default: step_d = SW_RI;
            endcase
        end
        if (clear_j) begin
            j_d = '0;
        end
    end

    // The sum is swap-invariant, so pre-swap captures give the post-swap index.
    assign f_idx = si_q + sj_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= SW_RI;
            j_q    <= '0;
            si_q   <= '0;
            sj_q   <= '0;
        end else begin
            step_q <= step_d;
            j_q    <= j_d;
            si_q   <= si_d;
            sj_q   <= sj_d;
        end
    end

endmodule

// File: rtl/rc4_key_search.sv
// rc4_key_search -- RC4 decrypt / key-search engine.
// For each candidate key: S-box init, KSA, PRGA decrypting the ciphertext ROM
// into the plaintext RAM. Optional macro RC4_ASCII_FILTER_EN enables the text
// filter and range search; without it only key_base is decrypted and the run
// always ends in HIT.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 pulse, accepted only in IDLE
//   key_base, key_limit   inclusive candidate range
//   s_addr/s_wdata/s_wren/s_rdata   S RAM port
//   c_addr/c_rdata        ciphertext ROM port
//   p_addr/p_wdata/p_wren plaintext RAM port
//   busy, done, found, key_found    status
//
// state   | meaning
// IDLE    | waiting for start
// INIT    | S[i]=i, one write per cycle
// KSA     | key schedule, one swap sequence per i
// PRGA    | swap, keystream read, plaintext write per byte
// NEXT    | candidate rejected: advance or finish
// HIT     | candidate accepted: latch result
// DONE    | done pulse, start not yet accepted
module rc4_key_search
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES   = 3,
    parameter int SEARCH_BITS = 22,
    parameter int MSG_LEN     = 32,
    localparam int CW         = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SEARCH_BITS-1:0] key_base,
    input  logic [SEARCH_BITS-1:0] key_limit,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rdata,
    output logic [CW-1:0]          c_addr,
    input  logic [7:0]             c_rdata,
    output logic [CW-1:0]          p_addr,
    output logic [7:0]             p_wdata,
    output logic                   p_wren,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [SEARCH_BITS-1:0] key_found
);
    rc4_state_e             state_q, state_d;
    prga_step_e             pstep_q, pstep_d;
    logic [SEARCH_BITS-1:0] cand_q, cand_d;
    logic [SEARCH_BITS-1:0] key_found_q, key_found_d;
    logic                   found_q, found_d;
    logic [7:0]             i_q, i_d;
    logic [CW-1:0]          k_q, k_d;

    logic [8*KEY_BYTES-1:0] key_full, key_sh;
    logic [7:0]             key_byte, seq_i, pt;
    int                     kidx;
    logic                   seq_run, seq_clr_j, seq_wren, seq_last;
    logic [7:0]             seq_addr, seq_wdata, f_idx;
    swap_mode_e             seq_mode;

`ifdef RC4_ASCII_FILTER_EN
    logic [SEARCH_BITS-1:0] limit_q, limit_d;
`else
    logic unused_key_limit;
    assign unused_key_limit = ^key_limit;
`endif

    rc4_swap_seq u_swap (
        .clk      (clk),
        .reset    (reset),
        .run      (seq_run),
        .clear_j  (seq_clr_j),
        .mode     (seq_mode),
        .i_idx    (seq_i),
        .key_byte (key_byte),
        .s_rdata  (s_rdata),
        .s_addr   (seq_addr),
        .s_wdata  (seq_wdata),
        .s_wren   (seq_wren),
        .f_idx    (f_idx),
        .last     (seq_last)
    );

    always_comb begin
        key_full = '0;
        key_full[SEARCH_BITS-1:0] = cand_q;
        // Byte 0 of the key is the most significant byte.
        kidx     = int'(i_q) % KEY_BYTES;
        key_sh   = key_full >> (8 * (KEY_BYTES - 1 - kidx));
        key_byte = key_sh[7:0];
        seq_mode = (state_q == ST_KSA) ? SWAP_KSA : SWAP_PRGA;
        // PRGA pre-increments i for each byte; i_q advances after the byte.
        seq_i    = (state_q == ST_PRGA) ? i_q + 8'd1 : i_q;
        pt       = c_rdata ^ s_rdata;
    end

    always_comb begin
        state_d     = state_q;
        pstep_d     = pstep_q;
        cand_d      = cand_q;
        key_found_d = key_found_q;
        found_d     = found_q;
        i_d         = i_q;
        k_d         = k_q;
`ifdef RC4_ASCII_FILTER_EN
        limit_d     = limit_q;
`endif
        seq_run     = 1'b0;
        seq_clr_j   = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wren      = 1'b0;
        c_addr      = '0;
        p_addr      = '0;
        p_wdata     = '0;
        p_wren      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    found_d     = 1'b0;
                    key_found_d = '0;
                    cand_d      = key_base;
                    i_d         = '0;
                    k_d         = '0;
                    pstep_d     = PR_SWAP;
`ifdef RC4_ASCII_FILTER_EN
                    limit_d     = key_limit;
                    state_d     = (key_base > key_limit) ? ST_NEXT : ST_INIT;
`else
                    state_d     = ST_INIT;
`endif
                end
            end
            ST_INIT: begin
                busy    = 1'b1;
                s_addr  = i_q;
                s_wdata = i_q;
                s_wren  = 1'b1;
                i_d     = i_q + 8'd1;
                if (i_q == 8'(INIT_CYCLES - 1)) begin
                    seq_clr_j = 1'b1;
                    state_d   = ST_KSA;
                end
            end
            ST_KSA: begin
                busy    = 1'b1;
                seq_run = 1'b1;
                s_addr  = seq_addr;
                s_wdata = seq_wdata;
                s_wren  = seq_wren;
                if (seq_last) begin
                    i_d = i_q + 8'd1;
                    if (i_q == 8'(INIT_CYCLES - 1)) begin
                        seq_clr_j = 1'b1;
                        k_d       = '0;
                        pstep_d   = PR_SWAP;
                        state_d   = ST_PRGA;
                    end
                end
            end
            ST_PRGA: begin
                busy   = 1'b1;
                c_addr = k_q;
                p_addr = k_q;
                unique case (pstep_q)
                    PR_SWAP: begin
                        seq_run = 1'b1;
                        s_addr  = seq_addr;
                        s_wdata = seq_wdata;
                        s_wren  = seq_wren;
                        if (seq_last) begin
                            pstep_d = PR_RF;
                        end
                    end
                    PR_RF: begin
                        s_addr  = f_idx;
                        pstep_d = PR_WF;
                    end
                    PR_WF: begin
                        s_addr  = f_idx;
                        pstep_d = PR_OUT;
                    end
                    PR_OUT: begin
                        // Address held so the keystream byte is still on s_rdata.
                        s_addr  = f_idx;
                        p_wdata = pt;
                        p_wren  = 1'b1;
                        i_d     = i_q + 8'd1;
                        k_d     = k_q + CW'(1);
                        pstep_d = PR_SWAP;
`ifdef RC4_ASCII_FILTER_EN
                        if (!is_text(pt)) begin
                            state_d = ST_NEXT;
                        end else if (k_q == CW'(MSG_LEN - 1)) begin
                            state_d = ST_HIT;
                        end
`else
                        if (k_q == CW'(MSG_LEN - 1)) begin
                            state_d = ST_HIT;
                        end
`endif
                    end
                    default: pstep_d = PR_SWAP;
                endcase
            end
            ST_NEXT: begin
                busy = 1'b1;
`ifdef RC4_ASCII_FILTER_EN
                // >= also covers an empty range; equality stops before wrap.
                if (cand_q >= limit_q) begin
                    state_d = ST_DONE;
                end else begin
                    cand_d  = cand_q + SEARCH_BITS'(1);
                    i_d     = '0;
                    k_d     = '0;
                    pstep_d = PR_SWAP;
                    state_d = ST_INIT;
                end
`else
                state_d = ST_DONE;
`endif
            end
            ST_HIT: begin
                busy        = 1'b1;
                found_d     = 1'b1;
                key_found_d = cand_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign found     = found_q;
    assign key_found = key_found_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pstep_q     <= PR_SWAP;
            cand_q      <= '0;
            key_found_q <= '0;
            found_q     <= 1'b0;
            i_q         <= '0;
            k_q         <= '0;
        end else begin
            state_q     <= state_d;
            pstep_q     <= pstep_d;
            cand_q      <= cand_d;
            key_found_q <= key_found_d;
            found_q     <= found_d;
            i_q         <= i_d;
            k_q         <= k_d;
        end
    end

`ifdef RC4_ASCII_FILTER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            limit_q <= '0;
        end else begin
            limit_q <= limit_d;
        end
    end
`endif

endmodule

// File: doc/rc4_key_search.md
# rc4_key_search

Parametrised RC4 decryption and key-search engine; the successor to the fixed-key, fixed-length RC4 core. For each candidate key in a programmable range it runs S-box init, KSA and PRGA, decrypts a ciphertext ROM into a plaintext RAM, and stops at the first key whose plaintext passes the character filter. It sits between the board top level and three single-port memories: the S RAM, the ciphertext ROM and the plaintext RAM.

## Interface
- KEY_BYTES, 3: RC4 key length in bytes (1..16).
- SEARCH_BITS, 22: candidate counter width. Must be ≤ 8*KEY_BYTES. Zero-extended into the key MSBs.
- MSG_LEN, 32: message bytes (1..256).
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse. Sampled only in IDLE.
- key_base  in  SEARCH_BITS  first candidate.
- key_limit  in  SEARCH_BITS  last candidate (inclusive).
- s_addr / s_wdata / s_wren / s_rdata  out 8 / out 8 / out 1 / in 8  S RAM port.
- c_addr / c_rdata  out $clog2(MSG_LEN) / in 8  ciphertext ROM port.
- p_addr / p_wdata / p_wren  out $clog2(MSG_LEN) / out 8 / out 1  plaintext RAM port.
- busy  out 1  high from the cycle after an accepted start until done.
- done  out 1  one-cycle pulse at the end of a search.
- found  out 1  valid from done until the next accepted start.
- key_found  out SEARCH_BITS  winning candidate. Valid while found=1.

## Operation
- Memories: address registered on the clock edge; read data valid in the following cycle. Writes commit on the edge with wren=1.
- Key byte k = key[8*(KEY_BYTES-1-k) +: 8], so byte 0 is the MSB byte. The index used is i mod KEY_BYTES.
- All index and byte arithmetic is mod 256 (8-bit wrap).
- FSM states: IDLE → INIT → KSA → PRGA → (NEXT | HIT) → IDLE.
- INIT: writes S[i]=i for i=0..255. Then clears i and j.
- KSA, for i=0..255: read S[i]; j=j+S[i]+key[i mod KEY_BYTES]; read S[j]; write S[i]=S[j]; write S[j]=old S[i].
- PRGA, for k=0..MSG_LEN-1:
  - i=i+1; read S[i]; j=j+S[i]; read S[j]; swap.
  - f=S[S[i]+S[j]], using the post-swap values.
  - Write p[k]=c[k]^f.
- Filter: a byte passes if it is 0x61..0x7A or 0x20.
  - A failing byte is still written. PRGA then aborts → NEXT.
  - All MSG_LEN bytes pass → HIT.
- NEXT: if candidate == key_limit → done with found=0. Otherwise candidate+1 → INIT.
- HIT: found=1, key_found=candidate, done.
- key_base > key_limit: empty range. No memory writes. done with found=0.
- The counter never wraps: key_limit = all-ones terminates after that candidate.
- Reset values: busy=0, done=0, found=0, key_found=0, all wren=0, all addresses=0, FSM=IDLE.

## Timing
- Accepted start → INIT first write: 1 cycle.
- INIT: 256 cycles.
- KSA: 6 cycles per i (RI, WI, RJ, WJ, SI, SJ), 1536 total.
- PRGA: 9 cycles per byte (RI, WI, RJ, WJ, SI, SJ, RF, WF, OUT).
- c_addr=k is held for the whole byte. p_wren is asserted in OUT.
- Full candidate: 1792 + 9*MSG_LEN cycles, plus 1 for NEXT/HIT.
- Empty range: done 2 cycles after start.
- start while busy: ignored.
- start on the same cycle as done: ignored. FSM is not yet IDLE.
- reset mid-operation: IDLE on the next edge; outputs return to reset values. Memory contents are left as-is.

## Configuration
- RC4_ASCII_FILTER_EN defined: filter and multi-key search as above.
- RC4_ASCII_FILTER_EN undefined:
  - Filter logic is removed. Only key_base is tried; key_limit is ignored.
  - All MSG_LEN bytes are decrypted.
  - HIT is unconditional: found=1, key_found=key_base.

## Structure
- Package rc4_pkg holds:
  - the FSM state enum;
  - the filter range constants 0x61, 0x7A, 0x20;
  - the per-phase cycle constants.
- One sub-module, rc4_swap_seq: the shared 6-step read/read/write/write swap sequencer. KSA and PRGA both use it, with the j-update term selected by mode.

## Test plan
- INIT check: key_base=key_limit=0, filter off. After done, bench dumps the S RAM → matches a golden model for key 0x000000.
- Single decrypt: filter off, key 0x000249, 32-byte ciphertext from the reference model → plaintext RAM matches, found=1, key_found=0x000249.
- Search hit: range 0x000000..0x0003FF, plaintext "the quick brown fox jumps over a" encrypted under 0x000123 → found=1, key_found=0x000123. done cycle = start + 292*(1792+9*32+1) + 1 ± abort savings; the bench counts this exactly.
- Search miss: range 0x10..0x1F, no passing key → done with found=0. Final candidate is 0x1F.
- Empty range: key_base=5, key_limit=4 → done 2 cycles after start, found=0, no wren.
- Reset and ignored start:
  - reset asserted in KSA at i=100 → busy=0 next cycle; a fresh start reproduces the single-decrypt result.
  - A start pulse while busy has no effect.
